alt_vipitc130_common_mode_sequencer: RTL

Upstream stage of the one-hot-to-binary mode encoder in the clocked video output timing path. Takes per-mode match flags and picks the lowest-index matching mode. The choice must stay stable for STABLE_FRAMES consecutive frame boundaries, and then a req/ack handshake with the timing generator completes before the new mode is committed. Its one_hot output feeds the encoder directly: at most one bit is set, and all-zero means "no mode", which the encoder reports as binary 0.

---
 rtl/alt_vipitc130_common_pkg.sv | 16 +
 rtl/alt_vipitc130_common_lsb_isolate.sv | 15 +
 rtl/alt_vipitc130_common_mode_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alt_vipitc130_common_pkg.sv
// Shared definitions for the clocked-video-output mode sequencer slice:
// FSM state encodings and elaboration-time parameter checks.
package alt_vipitc130_common_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_REQUEST = 2'd2;

  // True when stable_frames fits the qualification counter (1..2**cnt_width-1).
  function automatic bit cnt_width_ok(input int stable_frames, input int cnt_width);
    longint unsigned limit;
    limit = (64'd1 << cnt_width) - 64'd1;
    return (stable_frames >= 1) && (longint'(stable_frames) <= longint'(limit));
  endfunction

endpackage

// File: rtl/alt_vipitc130_common_lsb_isolate.sv
// Lowest-set-bit isolator: keeps only the least significant 1 of i_vec.
// All-zero input gives all-zero output.
module alt_vipitc130_common_lsb_isolate #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_vec
);

  logic [WIDTH-1:0] w_dec;

  assign w_dec = i_vec - WIDTH'(1);
  assign o_vec = i_vec & ~w_dec;

endmodule

// File: rtl/alt_vipitc130_common_mode_sequencer.sv
// Picks the lowest matching timing mode, qualifies it over STABLE_FRAMES
// frame boundaries, then commits it after a req/ack handshake.
module alt_vipitc130_common_mode_sequencer
  import alt_vipitc130_common_pkg::*;
#(
  parameter int NO_OF_MODES   = 3,
  parameter int STABLE_FRAMES = 2,
  parameter int CNT_WIDTH     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   eof,
  input  logic [NO_OF_MODES-1:0] match,
  input  logic                   change_ack,
  output logic                   change_req,
  output logic [NO_OF_MODES-1:0] req_one_hot,
  output logic [NO_OF_MODES-1:0] one_hot,
  output logic                   mode_valid,
  output logic                   mode_changed
);

  localparam logic [CNT_WIDTH-1:0] STABLE_CNT = CNT_WIDTH'(STABLE_FRAMES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  generate
    if (!cnt_width_ok(STABLE_FRAMES, CNT_WIDTH)) begin : g_bad_params
      $error("STABLE_FRAMES must be in 1..2**CNT_WIDTH-1");
    end
  endgenerate

  logic [1:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [NO_OF_MODES-1:0] r_pending;
  logic [NO_OF_MODES-1:0] r_one_hot;
  logic [NO_OF_MODES-1:0] r_req_one_hot;
  logic                   r_change_req;
  logic                   r_mode_valid;
  logic                   r_mode_changed;

  logic [NO_OF_MODES-1:0] w_cand;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [1:0]             w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [NO_OF_MODES-1:0] w_pending_nxt;
  logic                   w_req_set;
  logic                   w_commit;

  alt_vipitc130_common_lsb_isolate #(
    .WIDTH (NO_OF_MODES)
  ) u_lsb_isolate (
    .i_vec (match),
    .o_vec (w_cand)
  );

  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_req_set     = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (eof && enable && (w_cand != r_one_hot)) begin
          w_pending_nxt = w_cand;
          w_cnt_nxt     = CNT_ONE;
          if (STABLE_FRAMES == 1) begin
            w_state_nxt = ST_REQUEST;
            w_req_set   = 1'b1;
          end else begin
            w_state_nxt = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        // Losing enable takes priority over a coincident eof.
        if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (eof) begin
          if (w_cand == r_pending) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == STABLE_CNT) begin
              w_state_nxt = ST_REQUEST;
              w_req_set   = 1'b1;
            end
          end else if (w_cand == r_one_hot) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_pending_nxt = w_cand;
            w_cnt_nxt     = CNT_ONE;
          end
        end
      end
      ST_REQUEST: begin
        // Only the ack or a reset leaves REQUEST; eof/match/enable are ignored.
        if (change_ack) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_pending      <= '0;
      r_one_hot      <= '0;
      r_req_one_hot  <= '0;
      r_change_req   <= 1'b0;
      r_mode_valid   <= 1'b0;
      r_mode_changed <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_pending      <= w_pending_nxt;
      r_mode_changed <= w_commit;
      if (w_req_set) begin
        r_change_req  <= 1'b1;
        r_req_one_hot <= w_pending_nxt;
      end else if (w_commit) begin
        r_change_req  <= 1'b0;
        r_req_one_hot <= '0;
      end
      if (w_commit) begin
        r_one_hot    <= r_pending;
        r_mode_valid <= |r_pending;
      end
    end
  end

  assign change_req   = r_change_req;
  assign req_one_hot  = r_req_one_hot;
  assign one_hot      = r_one_hot;
  assign mode_valid   = r_mode_valid;
  assign mode_changed = r_mode_changed;

endmodule
